vec_regfile: RTL and testbench

- Vector register file that feeds the lane-parallel vector ALU, which performs the 16 lane operations with an optional scalar-broadcast B operand.
- Holds NREGS vector registers, each `element` lanes of `element` bits.
- Two combinational read ports supply vectorA/vectorB to the ALU. One synchronous write port with a per-lane mask takes the ALU result from writeback.
- A lane-extract read port supplies one element to the scalar datapath.

---
 rtl/vec_regfile_if.sv | 20 ++
 rtl/vec_regfile.sv | 39 +++
 tb/tb_vec_regfile.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vec_regfile_if.sv
// vec_regfile_if: read, write and lane-extract ports of the vector register file
interface vec_regfile_if #(
   parameter int element = 16,
   parameter int AW      = 3
);
   logic [AW-1:0]                   ra_addr, rb_addr, w_addr, rx_addr;
   logic [element-1:0][element-1:0] ra_data, rb_data, w_data;
   logic                            we;
   logic [element-1:0]              w_mask, rx_data;
   logic [$clog2(element)-1:0]      rx_lane;
   logic [15:0]                     wr_count;
   modport master (
      output ra_addr, rb_addr, we, w_addr, w_mask, w_data, rx_addr, rx_lane,
      input  ra_data, rb_data, rx_data, wr_count
   );
   modport slave (
      input  ra_addr, rb_addr, we, w_addr, w_mask, w_data, rx_addr, rx_lane,
      output ra_data, rb_data, rx_data, wr_count
   );
endinterface

// File: rtl/vec_regfile.sv
// vec_regfile: masked-write vector register file with bypassed reads and lane extract
module vec_regfile #(
   parameter int element = 16,
   parameter int NREGS   = 8,
   parameter int AW      = 3
) (
   input logic          clk,
   input logic          rst_n,
   vec_regfile_if.slave bus
);
   typedef logic [element-1:0][element-1:0] vec_t;
   localparam logic [AW:0] NR = (AW+1)'(NREGS);
   vec_t regs [NREGS];
   vec_t cur, nxt, ra_v, rb_v, rx_v;
   logic w_ok;
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NR;
   endfunction
   // Gating with rst_n keeps the bypass from leaking write data while in reset
   assign w_ok = rst_n && bus.we && in_range(bus.w_addr);
   always_comb begin
      cur = in_range(bus.w_addr) ? regs[bus.w_addr] : '0;
      for (int i = 0; i < element; i++) nxt[i] = bus.w_mask[i] ? bus.w_data[i] : cur[i];
      ra_v = !in_range(bus.ra_addr) ? '0 : (w_ok && bus.ra_addr == bus.w_addr) ? nxt : regs[bus.ra_addr];
      rb_v = !in_range(bus.rb_addr) ? '0 : (w_ok && bus.rb_addr == bus.w_addr) ? nxt : regs[bus.rb_addr];
      rx_v = !in_range(bus.rx_addr) ? '0 : (w_ok && bus.rx_addr == bus.w_addr) ? nxt : regs[bus.rx_addr];
   end
   assign bus.ra_data = ra_v;
   assign bus.rb_data = rb_v;
   assign bus.rx_data = rx_v[bus.rx_lane];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
         bus.wr_count <= '0;
      end else if (w_ok) begin
         regs[bus.w_addr] <= nxt;
         bus.wr_count     <= bus.wr_count + 16'd1;
      end
endmodule

// File: tb/tb_vec_regfile.sv
// tb_vec_regfile: random and directed checks of vec_regfile against an array model
module tb_vec_regfile;
   typedef logic [255:0] vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   vec_regfile_if bus ();
   vec_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   logic [15:0] m [8][16];
   logic [15:0] cnt;
   int n_vec = 0;
   int n_err = 0;
   vec_t v;
   task automatic check(input string tag, input vec_t got, input vec_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic vec_t model_rd(input int a);
      vec_t r;
      for (int i = 0; i < 16; i++)
         r[i*16 +: 16] = (rst_n && bus.we && a == int'(bus.w_addr) && bus.w_mask[i]) ? bus.w_data[i] : m[a][i];
      return r;
   endfunction
   function automatic vec_t rnd_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   task automatic model_reset();
      for (int r = 0; r < 8; r++) for (int i = 0; i < 16; i++) m[r][i] = '0;
      cnt = '0;
   endtask
   task automatic drive(input logic we, input int wa, input logic [15:0] wm, input vec_t wd,
                        input int ra, input int rb, input int rx, input int lane);
      @(negedge clk);
      bus.we = we; bus.w_addr = 3'(wa); bus.w_mask = wm; bus.w_data = wd;
      bus.ra_addr = 3'(ra); bus.rb_addr = 3'(rb); bus.rx_addr = 3'(rx); bus.rx_lane = 4'(lane);
   endtask
   task automatic commit();
      @(posedge clk);
      if (rst_n && bus.we) begin
         for (int i = 0; i < 16; i++) if (bus.w_mask[i]) m[bus.w_addr][i] = bus.w_data[i];
         cnt++;
      end
      #1;
   endtask
   task automatic tick();
      vec_t x;
      #1;
      check("ra", bus.ra_data, model_rd(bus.ra_addr));
      check("rb", bus.rb_data, model_rd(bus.rb_addr));
      x = model_rd(bus.rx_addr);
      check("rx", vec_t'(bus.rx_data), vec_t'(x[bus.rx_lane*16 +: 16]));
      commit();
      check("wr_count", vec_t'(bus.wr_count), vec_t'(cnt));
   endtask
   initial begin
      model_reset();
      bus.we = 1'b1; bus.w_addr = 3'd2; bus.w_mask = 16'hFFFF; bus.w_data = {16{16'hABCD}};
      bus.ra_addr = 3'd2; bus.rb_addr = 3'd2; bus.rx_addr = 3'd2; bus.rx_lane = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ra", bus.ra_data, '0);
      check("rst_rx", vec_t'(bus.rx_data), '0);
      check("rst_cnt", vec_t'(bus.wr_count), '0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.we = 1'b0;
      for (int r = 0; r < 8; r++) begin
         drive(0, 0, 0, '0, r, 7 - r, r, r * 2);
         #1 check("post_rst_ra", bus.ra_data, '0);
         tick();
      end
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h0100 + 16'(i);
      drive(1, 3, 16'hFFFF, v, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, '0, 3, 3, 3, 5);
      #1;
      check("full_ra", bus.ra_data, v);
      check("full_rb", bus.rb_data, v);
      check("full_cnt", vec_t'(bus.wr_count), 256'd1);
      tick();
      drive(1, 3, 16'h00F0, {16{16'hFFFF}}, 3, 3, 3, 4);
      tick();
      drive(0, 0, 0, '0, 3, 0, 3, 8);
      for (int i = 4; i < 8; i++) v[i*16 +: 16] = 16'hFFFF;
      #1 check("mask_ra", bus.ra_data, v);
      tick();
      drive(1, 5, 16'h0001, {16{16'h1234}}, 5, 4, 5, 0);
      #1;
      check("byp_ra", bus.ra_data, 256'h1234);
      check("byp_rb", bus.rb_data, '0);
      check("byp_rx", vec_t'(bus.rx_data), 256'h1234);
      tick();
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'hA000 + 16'(i);
      drive(1, 7, 16'hFFFF, v, 0, 0, 0, 0);
      tick();
      for (int l = 0; l < 16; l++) begin
         drive(0, 0, 0, '0, 7, 7, 7, l);
         #1 check("sweep_rx", vec_t'(bus.rx_data), vec_t'(16'hA000 + 16'(l)));
         tick();
      end
      for (int k = 0; k < 300; k++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), 16'($urandom()), rnd_vec(),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
         tick();
      end
      drive(1, 1, 0, rnd_vec(), 1, 1, 1, 3);
      repeat (1000) commit();
      @(negedge clk);
      bus.we = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_cnt", vec_t'(bus.wr_count), '0);
      check("async_ra", bus.ra_data, '0);
      model_reset();
      #1 rst_n = 1'b1;
      v = rnd_vec();
      drive(1, 1, 16'hFFFF, v, 1, 1, 1, 0);
      tick();
      drive(1, 1, 16'h0000, ~v, 1, 1, 1, 9);
      repeat (65535) commit();
      check("wrap_cnt", vec_t'(bus.wr_count), '0);
      check("wrap_model_cnt", vec_t'(bus.wr_count), vec_t'(cnt));
      check("zero_mask_ra", bus.ra_data, v);
      drive(0, 0, 0, '0, 1, 1, 1, 9);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
